// File: rtl/imem_loader_if.sv
// imem_loader_if
//  Groups the loader's byte-stream handshake and the instruction-memory byte
//  write port.
//  Stream  : in_data, in_valid (source -> loader), in_ready (loader -> source)
//  Memory  : mem_we, mem_addr, mem_wdata (loader -> instruction memory)
//  Modports: master = stream source / memory observer, slave = the loader.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//  Writer side of the instruction memory. Takes a framed byte stream
//  (COUNT=N, 4*N data bytes, CSUM=XOR of the data bytes) and writes data byte
//  k to memory byte address k. The CPU is held while a load is in progress.
//  Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, begins a load when idle
//   abort      : level, aborts an active load (error)
//   bus        : stream handshake + memory byte write port (slave modport)
//   busy       : a load is in progress
//   cpu_hold   : same as busy; freezes the CPU
//   done/error : sticky result of the last load
//   ins_count  : N latched from the COUNT byte
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] ins_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNT  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  // Largest frame payload in bytes that fits the memory.
  localparam logic [31:0] MEM_BYTES = 32'd1 << ADDR_W;

  state_t            state_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic [CNT_W-1:0]  ins_count_r;
  // One extra bit so a full-memory frame (4*N == 2**ADDR_W) does not alias to 0.
  logic [ADDR_W:0]   idx_r;
  logic [ADDR_W:0]   total_r;
  logic [7:0]        csum_r;

  logic              take_s;
  logic [31:0]       quad_s;
  logic [ADDR_W:0]   idx_next_s;

  assign take_s     = bus.in_valid && in_ready_r;
  assign quad_s     = {22'd0, bus.in_data, 2'b00};
  assign idx_next_s = idx_r + (ADDR_W+1)'(1);

  // Load sequencer: state, handshake, memory write port and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      ins_count_r <= '0;
      idx_r       <= '0;
      total_r     <= '0;
      csum_r      <= 8'd0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold between writes.
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // abort wins over a simultaneous start and leaves the status alone.
          if (!abort && start) begin
            state_r     <= ST_CNT;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            ins_count_r <= '0;
            idx_r       <= '0;
            total_r     <= '0;
            csum_r      <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CNT, ST_DATA, ST_CSUM: begin
          if (abort) begin
            // Byte presented in the abort cycle is dropped.
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            error_r    <= 1'b1;
          end else if (take_s) begin
            if (state_r == ST_CNT) begin
              ins_count_r <= CNT_W'(bus.in_data);
              total_r     <= (ADDR_W+1)'(quad_s);
              if (bus.in_data == 8'd0) begin
                state_r <= ST_CSUM;
              end else if (quad_s > MEM_BYTES) begin
                state_r    <= ST_IDLE;
                in_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                error_r    <= 1'b1;
              end else begin
                state_r <= ST_DATA;
              end
            end else if (state_r == ST_DATA) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= idx_r[ADDR_W-1:0];
              mem_wdata_r <= bus.in_data;
              csum_r      <= csum_r ^ bus.in_data;
              idx_r       <= idx_next_s;
              if (idx_next_s == total_r) begin
                state_r <= ST_CSUM;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              state_r    <= ST_IDLE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              if (bus.in_data == csum_r) begin
                done_r <= 1'b1;
              end else begin
                error_r <= 1'b1;
              end
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign busy          = busy_r;
  assign cpu_hold      = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign ins_count     = ins_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//  Directed self-checking bench for imem_loader. Inputs are driven on the
//  falling clock edge, outputs sampled there too (away from the rising edge).
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] ins_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .ins_count (ins_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int we_total = 0;
  int base;
  int exp_addr;
  logic [7:0] prog [8];

  // Count write strobes (value present in the cycle before each rising edge).
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) we_total <= we_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte until accepted (bounded). Data bytes must show their
  // write in the cycle right after the accept edge. With gap, in_valid stays
  // low for one cycle afterwards and the strobe must have dropped.
  task automatic send(input logic [7:0] b, input bit is_data, input bit gap);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
    if (ok && is_data) begin
      chk("mem_we", 32'(bus.mem_we), 32'd1);
      chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(b));
      exp_addr++;
    end
    if (gap) begin
      @(negedge clk);
      if (is_data) chk("we_single", 32'(bus.mem_we), 32'd0);
    end
  endtask

  initial begin
    // XOR of the eight data bytes is 0x98.
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h08; prog[6] = 8'h10; prog[7] = 8'h00;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;

    // 1. reset with in_valid high
    idle(2);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    idle(2);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // 2. good frame, back-to-back bytes
    base = we_total;
    pulse_start();
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    exp_addr = 0;
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(prog[i], 1'b1, 1'b0);
    send(8'h98, 1'b0, 1'b0);
    chk("t2_busy_end", 32'(busy), 32'd0);
    idle(2);
    chk("t2_writes", 32'(we_total - base), 32'd8);
    chk("t2_count", 32'(ins_count), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_error", 32'(error), 32'd0);
    chk("t2_hold_end", 32'(cpu_hold), 32'd0);

    // 3. same frame, bad checksum
    base = we_total;
    pulse_start();
    chk("t3_done_clr", 32'(done), 32'd0);
    exp_addr = 0;
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(prog[i], 1'b1, 1'b0);
    send(8'h19, 1'b0, 1'b0);
    idle(2);
    chk("t3_writes", 32'(we_total - base), 32'd8);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);

    // 4. empty frames
    base = we_total;
    pulse_start();
    chk("t4_err_clr", 32'(error), 32'd0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    idle(2);
    chk("t4a_writes", 32'(we_total - base), 32'd0);
    chk("t4a_done", 32'(done), 32'd1);
    chk("t4a_count", 32'(ins_count), 32'd0);
    pulse_start();
    send(8'h00, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b0);
    idle(2);
    chk("t4b_error", 32'(error), 32'd1);
    chk("t4b_done", 32'(done), 32'd0);

    // 5. in_valid toggling, start mid-frame ignored
    base = we_total;
    pulse_start();
    exp_addr = 0;
    send(8'h02, 1'b0, 1'b1);
    pulse_start();
    chk("t5_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send(prog[i], 1'b1, 1'b1);
    send(8'h98, 1'b0, 1'b1);
    idle(1);
    chk("t5_writes", 32'(we_total - base), 32'd8);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_count", 32'(ins_count), 32'd2);

    // 6a. abort after three data bytes
    base = we_total;
    pulse_start();
    exp_addr = 0;
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(prog[i], 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    idle(3);
    chk("t6_ready_hold", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    chk("t6_writes", 32'(we_total - base), 32'd3);

    // abort and start together while idle: stay idle, error kept
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    idle(1);
    chk("t6_abst_busy", 32'(busy), 32'd0);
    chk("t6_abst_error", 32'(error), 32'd1);

    // 6b. reset pulse mid-frame, right while a write strobe is high
    pulse_start();
    exp_addr = 0;
    send(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(prog[i], 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_hold", 32'(cpu_hold), 32'd0);
    chk("t6r_ready", 32'(bus.in_ready), 32'd0);
    chk("t6r_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t6r_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("t6r_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("t6r_count", 32'(ins_count), 32'd0);
    chk("t6r_done", 32'(done), 32'd0);
    chk("t6r_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
